// File: rtl/mpeg_mv_pkg.sv
// mpeg_mv_pkg: shared MPEG motion-vector FSM states and f/lim derivation from r_size
package mpeg_mv_pkg;
  typedef enum logic [1:0] {IDLE, ENC_H, ENC_V, OUT} mv_state_e;
  function automatic logic signed [39:0] mv_lim(logic [4:0] r);
    return 40'sd16 <<< r;
  endfunction
  function automatic logic signed [39:0] mv_f(logic [4:0] r);
    return 40'sd1 <<< r;
  endfunction
endpackage

// File: rtl/encode_motion_vector_if.sv
// encode_motion_vector_if: in_valid/in_ready target pair in, out_valid/out_ready codes, residuals, range_err out
interface encode_motion_vector_if;
  logic in_valid, in_ready, full_pel_vector, pred_reset, out_valid, out_ready, range_err;
  logic signed [31:0] target_h, target_v, motion_code_h, motion_code_v;
  logic [31:0] motion_residual_h, motion_residual_v;
  modport master (
    output in_valid, target_h, target_v, full_pel_vector, pred_reset, out_ready,
    input in_ready, out_valid, motion_code_h, motion_code_v, motion_residual_h, motion_residual_v, range_err
  );
  modport slave (
    input in_valid, target_h, target_v, full_pel_vector, pred_reset, out_ready,
    output in_ready, out_valid, motion_code_h, motion_code_v, motion_residual_h, motion_residual_v, range_err
  );
endinterface

// File: rtl/mv_component_encoder.sv
// mv_component_encoder: target/pred/full_pel in -> code, residual, wrapped predictor update, range error out
module mv_component_encoder
  import mpeg_mv_pkg::*;
#(
  parameter int R_SIZE = 3
) (
  input  logic signed [31:0] target,
  input  logic signed [31:0] pred,
  input  logic               full_pel,
  output logic signed [31:0] code,
  output logic        [31:0] residual,
  output logic signed [31:0] recon,
  output logic               err
);
  localparam logic [4:0] R = R_SIZE[4:0];
  localparam logic signed [39:0] LIM = mv_lim(R);
  localparam logic signed [39:0] F = mv_f(R);
  logic signed [39:0] t, p, dr, d, a, wt;
  always_comb begin
    t = full_pel ? 40'(target >>> 1) : 40'(target);
    p = full_pel ? 40'(pred >>> 1) : 40'(pred);
    dr = t - p;
    d = dr >= LIM ? dr - (LIM <<< 1) : dr < -LIM ? dr + (LIM <<< 1) : dr;
    a = (d < 40'sd0 ? -d : d) - 40'sd1;
    code = d == 40'sd0 ? '0 : d < 40'sd0 ? -32'((a >>> R) + 40'sd1) : 32'((a >>> R) + 40'sd1);
    residual = d == 40'sd0 ? '0 : 32'(a & (F - 40'sd1));
    wt = ((t + LIM) & ((LIM <<< 1) - 40'sd1)) - LIM;
    recon = full_pel ? 32'(wt <<< 1) : 32'(wt);
    err = t < -LIM || t >= LIM;
  end
endmodule

// File: rtl/encode_motion_vector.sv
// encode_motion_vector: clk, rst, io (slave) -- encodes H then V target vectors into motion code/residual pairs
module encode_motion_vector
  import mpeg_mv_pkg::*;
#(
  parameter int R_SIZE = 3
) (
  input logic clk,
  input logic rst,
  encode_motion_vector_if.slave io
);
  mv_state_e state, state_nx;
  logic signed [31:0] pred_h, pred_v, tgt_h, tgt_v, code, recon, code_h, code_v;
  logic [31:0] residual, res_h, res_v;
  logic fp, err, err_h, range_err, enc_v;
  assign enc_v = state == ENC_V;
  mv_component_encoder #(.R_SIZE(R_SIZE)) u_enc (
    .target(enc_v ? tgt_v : tgt_h),
    .pred(enc_v ? pred_v : pred_h),
    .full_pel(fp),
    .code(code),
    .residual(residual),
    .recon(recon),
    .err(err)
  );
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (io.in_valid ? ENC_H : IDLE) :
               state == ENC_H ? ENC_V :
               state == ENC_V ? OUT :
               (io.out_ready ? IDLE : OUT);
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_h <= '0;
      pred_v <= '0;
      tgt_h <= '0;
      tgt_v <= '0;
      fp <= 1'b0;
      code_h <= '0;
      code_v <= '0;
      res_h <= '0;
      res_v <= '0;
      err_h <= 1'b0;
      range_err <= 1'b0;
    end else begin
      if (state == IDLE && io.in_valid) begin
        tgt_h <= io.target_h;
        tgt_v <= io.target_v;
        fp <= io.full_pel_vector;
      end
      if (state == IDLE && io.pred_reset) begin
        pred_h <= '0;
        pred_v <= '0;
      end
      if (state == ENC_H) begin
        code_h <= code;
        res_h <= residual;
        pred_h <= recon;
        err_h <= err;
      end
      if (enc_v) begin
        code_v <= code;
        res_v <= residual;
        pred_v <= recon;
        range_err <= err_h | err;
      end
    end
  end
  assign io.in_ready = state == IDLE;
  assign io.out_valid = state == OUT;
  assign io.motion_code_h = code_h;
  assign io.motion_code_v = code_v;
  assign io.motion_residual_h = res_h;
  assign io.motion_residual_v = res_v;
  assign io.range_err = range_err;
endmodule
